// File: rtl/conbox_cfg_loader_if.sv
// Handshake and configuration bundle between a bitstream source and one
// conbox configuration loader. Also carries the loader's FSM state and bit count.
interface conbox_cfg_loader_if #(
    parameter int CFG_W = 20,
    parameter int CNT_W = 6
);
    // cfg_in is transferred on every rising clk edge where cfg_en (== cfg_ready)
    // and cfg_valid are both high; cfg_out is qualified only by cfg_out_valid.
    logic             cfg_en;
    logic             cfg_in;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_out;
    logic             cfg_out_valid;
    logic             cfg_commit;
    logic [CFG_W-1:0] config_dataA;
    logic [CFG_W-1:0] config_dataB;
    logic             cfg_loaded;
    logic             cfg_error;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_count;

    modport slave (
        input  cfg_en, cfg_in, cfg_valid, cfg_commit,
        output cfg_ready, cfg_out, cfg_out_valid,
        output config_dataA, config_dataB, cfg_loaded, cfg_error,
        output dbg_state, dbg_count
    );

    modport master (
        output cfg_en, cfg_in, cfg_valid, cfg_commit,
        input  cfg_ready, cfg_out, cfg_out_valid,
        input  config_dataA, config_dataB, cfg_loaded, cfg_error,
        input  dbg_state, dbg_count
    );
endinterface

// File: rtl/conbox_cfg_loader.sv
// Serial configuration loader for one conbox: shifts bits into a shadow register,
// forwards overflow down the daisy chain, and commits validated shadows to the active selects.
module conbox_cfg_loader #(
    parameter int WIDTH      = 8,
    parameter int LE_OUTPUTS = 1,
    parameter int LE_INPUTS  = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    conbox_cfg_loader_if.slave bus
);
    localparam int SEL_BITS = $clog2(WIDTH + 2);
    localparam int NFIELD   = LE_INPUTS + LE_OUTPUTS;
    localparam int CFG_W    = SEL_BITS * NFIELD;
    localparam int TOTAL    = 2 * CFG_W;
    localparam int CNT_W    = $clog2(TOTAL + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(TOTAL);
    localparam logic [SEL_BITS-1:0] SEL_MAX  = SEL_BITS'(WIDTH + 1);

    // Every field selects CONST_0 (index WIDTH): LE inputs tied low, no bus driven.
    function automatic logic [CFG_W-1:0] rst_image();
        logic [CFG_W-1:0] img;
        img = '0;
        for (int i = 0; i < NFIELD; i++) begin
            img[i*SEL_BITS +: SEL_BITS] = SEL_BITS'(WIDTH);
        end
        return img;
    endfunction

    localparam logic [CFG_W-1:0] RST_IMG = rst_image();

    logic [TOTAL-1:0] r_shadow;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_state;
    logic             r_cfg_out;
    logic             r_cfg_out_valid;
    logic [CFG_W-1:0] r_data_a;
    logic [CFG_W-1:0] r_data_b;
    logic             r_loaded;
    logic             r_error;

    logic             w_accept;
    logic             w_start;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_state_next;
    logic             w_fields_ok;
    logic             w_commit_ok;
    logic             w_commit_bad;

    assign w_accept = bus.cfg_en & bus.cfg_valid;
    // Leaving IDLE with cfg_en high opens a frame; a bit accepted on that same edge is the frame's first.
    assign w_start    = (r_state == ST_IDLE) & bus.cfg_en;
    assign w_cnt_base = w_start ? '0 : r_cnt;
    assign w_cnt_next = (w_accept && (w_cnt_base != CNT_FULL)) ? w_cnt_base + 1'b1 : w_cnt_base;

    always_comb begin
        w_fields_ok = 1'b1;
        for (int i = 0; i < 2 * NFIELD; i++) begin
            if (r_shadow[i*SEL_BITS +: SEL_BITS] > SEL_MAX) begin
                w_fields_ok = 1'b0;
            end
        end
    end

    // Decided on the pre-edge shadow and count, so a coincident shift cannot corrupt it.
    assign w_commit_ok  = bus.cfg_commit & (r_cnt == CNT_FULL) & w_fields_ok;
    assign w_commit_bad = bus.cfg_commit & ~w_commit_ok;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.cfg_en) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!bus.cfg_en)                 w_state_next = ST_IDLE;
                else if (w_cnt_next == CNT_FULL) w_state_next = ST_FULL;
            end
            ST_FULL: begin
                if (!bus.cfg_en) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shadow        <= {RST_IMG, RST_IMG};
            r_cfg_out       <= 1'b0;
            r_cfg_out_valid <= 1'b0;
        end else begin
            r_cfg_out_valid <= w_accept;
            if (w_accept) begin
                r_shadow  <= {bus.cfg_in, r_shadow[TOTAL-1:1]};
                r_cfg_out <= r_shadow[0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data_a <= RST_IMG;
            r_data_b <= RST_IMG;
            r_loaded <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_commit_ok) begin
                r_data_a <= r_shadow[CFG_W-1:0];
                r_data_b <= r_shadow[TOTAL-1:CFG_W];
                r_loaded <= 1'b1;
            end
            // A rejected commit on the frame-opening edge still reports.
            if (w_commit_bad)  r_error <= 1'b1;
            else if (w_start)  r_error <= 1'b0;
        end
    end

    assign bus.cfg_ready     = bus.cfg_en;
    assign bus.cfg_out       = r_cfg_out;
    assign bus.cfg_out_valid = r_cfg_out_valid;
    assign bus.config_dataA  = r_data_a;
    assign bus.config_dataB  = r_data_b;
    assign bus.cfg_loaded    = r_loaded;
    assign bus.cfg_error     = r_error;
    assign bus.dbg_state     = r_state;
    assign bus.dbg_count     = r_cnt;
endmodule

// File: tb/tb_conbox_cfg_loader.sv
// Self-checking bench for conbox_cfg_loader at default parameters (CFG_W=20, TOTAL=40).
module tb_conbox_cfg_loader;
  localparam int CFG_W = 20;
  localparam int TOTAL = 40;
  localparam logic [CFG_W-1:0] RST_IMG = 20'h88888;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  logic exp_q[$];    // expected cfg_out bits, pushed on accept
  logic model_q[$];  // bench model of the shadow, oldest bit first

  conbox_cfg_loader_if #(.CFG_W(20), .CNT_W(6)) bus ();

  conbox_cfg_loader dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    logic [2*CFG_W-1:0] img;
    img = {RST_IMG, RST_IMG};
    model_q.delete();
    exp_q.delete();
    for (int i = 0; i < TOTAL; i++) model_q.push_back(img[i]);
  endtask

  // one clock of stimulus; cfg_out is scored on every accept
  task automatic step(input logic en, input logic v, input logic b, input logic c);
    logic acc;
    bus.cfg_en     = en;
    bus.cfg_valid  = v;
    bus.cfg_in     = b;
    bus.cfg_commit = c;
    acc = en & v;
    if (acc) begin
      model_q.push_back(b);
      exp_q.push_back(model_q.pop_front());
    end
    @(posedge clk);
    #1;
    bus.cfg_commit = 1'b0;
    if (acc) begin
      check("cfg_out_valid_on_accept", 40'(bus.cfg_out_valid), 40'd1);
      if (exp_q.size() == 0) check("scoreboard_empty", 40'd1, 40'd0);
      else check("cfg_out_bit", 40'(bus.cfg_out), 40'(exp_q.pop_front()));
    end else begin
      check("cfg_out_valid_idle", 40'(bus.cfg_out_valid), 40'd0);
    end
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] a, input logic [CFG_W-1:0] b);
    logic [2*CFG_W-1:0] img;
    img = {b, a};
    for (int i = 0; i < TOTAL; i++) step(1'b1, 1'b1, img[i], 1'b0);
  endtask

  task automatic check_active(input string tag, input logic [CFG_W-1:0] a, input logic [CFG_W-1:0] b);
    check({tag, "_A"}, 40'(bus.config_dataA), 40'(a));
    check({tag, "_B"}, 40'(bus.config_dataB), 40'(b));
  endtask

  initial begin
    int accepts;
    n_tests = 0;
    n_fail  = 0;
    bus.cfg_en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_in = 1'b0;
    bus.cfg_commit = 1'b0;
    n_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // 1: reset state
    check_active("reset", RST_IMG, RST_IMG);
    check("reset_loaded", 40'(bus.cfg_loaded), 40'd0);
    check("reset_error", 40'(bus.cfg_error), 40'd0);
    check("reset_out_valid", 40'(bus.cfg_out_valid), 40'd0);
    check("reset_state", 40'(bus.dbg_state), 40'd0);
    check("cfg_ready_low", 40'(bus.cfg_ready), 40'd0);

    // 2: full frame then commit
    send_frame(20'h01234, 20'h98765);
    check("frame_count", 40'(bus.dbg_count), 40'd40);
    check("frame_state_full", 40'(bus.dbg_state), 40'd2);
    check_active("before_commit", RST_IMG, RST_IMG);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_active("commit_ok", 20'h01234, 20'h98765);
    check("commit_loaded", 40'(bus.cfg_loaded), 40'd1);
    check("commit_error", 40'(bus.cfg_error), 40'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("state_idle", 40'(bus.dbg_state), 40'd0);

    // 3: short frame rejected, error cleared by new frame
    for (int i = 0; i < TOTAL - 1; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("short_count", 40'(bus.dbg_count), 40'd39);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("short_error", 40'(bus.cfg_error), 40'd1);
    check_active("short_unchanged", 20'h01234, 20'h98765);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("error_cleared", 40'(bus.cfg_error), 40'd0);
    check("count_cleared", 40'(bus.dbg_count), 40'd0);

    // 4: out-of-range field rejected, corrected image accepted
    send_frame(20'h0123A, 20'h99990);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("badfield_error", 40'(bus.cfg_error), 40'd1);
    check_active("badfield_unchanged", 20'h01234, 20'h98765);
    send_frame(20'h05432, 20'h99990);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_active("fixed_commit", 20'h05432, 20'h99990);
    check("fixed_loaded", 40'(bus.cfg_loaded), 40'd1);

    // 5: 80 accepts with gaps; pass-through and count saturation
    step(1'b0, 1'b0, 1'b0, 1'b0);
    accepts = 0;
    while (accepts < 2 * TOTAL) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        accepts++;
      end
    end
    check("sat_count", 40'(bus.dbg_count), 40'd40);
    check_active("shift_no_disturb", 20'h05432, 20'h99990);

    // 6: commit coincident with the 41st accept, then mid-frame reset
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(20'h11223, 20'h45678);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_active("coincident_commit", 20'h11223, 20'h45678);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_active("midreset", RST_IMG, RST_IMG);
    check("midreset_loaded", 40'(bus.cfg_loaded), 40'd0);
    check("midreset_error", 40'(bus.cfg_error), 40'd0);
    check("midreset_out_valid", 40'(bus.cfg_out_valid), 40'd0);
    check("midreset_out", 40'(bus.cfg_out), 40'd0);
    check("midreset_count", 40'(bus.dbg_count), 40'd0);
    check("midreset_state", 40'(bus.dbg_state), 40'd0);
    bus.cfg_en = 1'b0;
    bus.cfg_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // shadow restored to reset image: its bits stream out first
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("queue_drained", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
